display_7seg_multiplexado: RTL

Parametrised successor to the fixed 4-digit hex display path, which was a parallel register plus a 7-segment driver. It latches a DATA_W-bit value on a write strobe and shows it on N_DIGITS multiplexed common-anode digits. Values can be shown in hex or in unsigned decimal; decimal uses a sequential double-dabble converter. Optional leading-zero blanking and overflow indication are included. It sits between the register-file read port (rs2) and the board anodes/segments.

---
 rtl/display_7seg_multiplexado.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/display_7seg_multiplexado.sv
// Multiplexed common-anode 7-segment display for an unsigned DATA_W-bit value,
// shown in hex or decimal (sequential double-dabble), with zero blanking and overflow dashes.
module display_7seg_multiplexado #(
    parameter int DATA_W      = 16,
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                we_i,
    input  logic [DATA_W-1:0]   dato_i,
    input  logic                modo_dec_i,
    input  logic                blank_lz_i,
    output logic [N_DIGITS-1:0] an_o,
    output logic [6:0]          seg_o,
    output logic                busy_o
);

    // floor(DATA_W*log10(2)) + 1 decimal digits cover every DATA_W-bit value
    localparam int BCD_DIGITS = ((DATA_W * 1233) >> 12) + 1;
    localparam int MAX_DIGITS = (BCD_DIGITS > N_DIGITS) ? BCD_DIGITS : N_DIGITS;
    localparam int BCD_W      = 4 * MAX_DIGITS;
    localparam int EXT_W      = (DATA_W > 4 * N_DIGITS) ? DATA_W : 4 * N_DIGITS;
    localparam int CNT_W      = $clog2(REFRESH_DIV);
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int ITER_W     = $clog2(DATA_W + 1);
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0: seg_decode = 7'b1000000;
            4'h1: seg_decode = 7'b1111001;
            4'h2: seg_decode = 7'b0100100;
            4'h3: seg_decode = 7'b0110000;
            4'h4: seg_decode = 7'b0011001;
            4'h5: seg_decode = 7'b0010010;
            4'h6: seg_decode = 7'b0000010;
            4'h7: seg_decode = 7'b1111000;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0010000;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b0000011;
            4'hC: seg_decode = 7'b1000110;
            4'hD: seg_decode = 7'b0100001;
            4'hE: seg_decode = 7'b0000110;
            default: seg_decode = 7'b0001110;
        endcase
    endfunction

    state_t                  r_state;
    logic                    r_busy;
    logic [DATA_W-1:0]       r_bin;
    logic [BCD_W-1:0]        r_bcd;
    logic [ITER_W-1:0]       r_iter;
    logic                    r_blank_pend;
    logic [4*N_DIGITS-1:0]   r_buf;
    logic                    r_blank;
    logic                    r_ovf;
    logic [CNT_W-1:0]        r_ref;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_active;
    logic [N_DIGITS-1:0]     r_an;
    logic [6:0]              r_seg;

    logic [EXT_W-1:0]        w_dato_ext;
    logic                    w_hex_ovf;
    logic [BCD_W-1:0]        w_bcd_adj;
    logic [BCD_W-1:0]        w_bcd_next;
    logic                    w_dec_ovf;
    logic                    w_wrap;
    logic [IDX_W-1:0]        w_idx_next;
    logic                    w_active_next;
    logic [N_DIGITS-1:0]     w_lit;
    logic [3:0]              w_digit;
    logic [N_DIGITS-1:0]     w_an_next;
    logic [6:0]              w_seg_next;

    assign w_dato_ext = EXT_W'(dato_i);

    generate
        if (DATA_W > 4 * N_DIGITS) begin : g_hex_ovf
            assign w_hex_ovf = |dato_i[DATA_W-1:4*N_DIGITS];
        end else begin : g_no_hex_ovf
            assign w_hex_ovf = 1'b0;
        end
    endgenerate

    // One double-dabble step: add 3 to every BCD digit >= 5, then shift the next binary bit in
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no latch can be inferred.
        w_bcd_adj = r_bcd;
        for (int d = 0; d < MAX_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
        w_bcd_next = BCD_W'({w_bcd_adj, r_bin[DATA_W-1]});
    end

    always_comb begin
        w_dec_ovf = 1'b0;
        for (int d = N_DIGITS; d < MAX_DIGITS; d++) begin
            w_dec_ovf = w_dec_ovf | (w_bcd_next[4*d +: 4] != 4'd0);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_iter       <= '0;
            r_blank_pend <= 1'b0;
            r_buf        <= '0;
            r_blank      <= 1'b0;
            r_ovf        <= 1'b0;
        end else if (we_i) begin
            if (modo_dec_i) begin
                r_state      <= S_CONV;
                r_busy       <= 1'b1;
                r_bin        <= dato_i;
                r_bcd        <= '0;
                r_iter       <= '0;
                r_blank_pend <= blank_lz_i;
            end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_buf   <= w_dato_ext[4*N_DIGITS-1:0];
                r_blank <= blank_lz_i;
                r_ovf   <= w_hex_ovf;
            end
        end else if (r_state == S_CONV) begin
            r_bin  <= {r_bin[DATA_W-2:0], 1'b0};
            r_bcd  <= w_bcd_next;
            r_iter <= r_iter + ITER_W'(1);
            if (r_iter == ITER_W'(DATA_W - 1)) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_buf   <= w_bcd_next[4*N_DIGITS-1:0];
                r_blank <= r_blank_pend;
                r_ovf   <= w_dec_ovf;
            end
        end
    end

    // The first wrap after reset lights digit 0 without advancing the index
    assign w_wrap        = (r_ref == CNT_W'(REFRESH_DIV - 1));
    assign w_active_next = r_active | w_wrap;
    assign w_idx_next    = (w_wrap && r_active)
                         ? ((r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1))
                         : r_idx;

    always_comb begin
        logic seen;
        seen  = 1'b0;
        w_lit = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            seen     = seen | (r_buf[4*k +: 4] != 4'd0);
            w_lit[k] = seen | (k == 0);
        end
    end

    assign w_digit = r_buf[4*w_idx_next +: 4];

    always_comb begin
        w_an_next  = '1;
        w_seg_next = 7'b1111111;
        if (w_active_next) begin
            if (r_ovf) begin
                w_an_next  = ~(N_DIGITS'(1) << w_idx_next);
                w_seg_next = SEG_DASH;
            end else if (!r_blank || w_lit[w_idx_next]) begin
                w_an_next  = ~(N_DIGITS'(1) << w_idx_next);
                w_seg_next = seg_decode(w_digit);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_ref    <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_an     <= '1;
            r_seg    <= 7'b1111111;
        end else begin
            r_ref    <= w_wrap ? '0 : r_ref + CNT_W'(1);
            r_idx    <= w_idx_next;
            r_active <= w_active_next;
            r_an     <= w_an_next;
            r_seg    <= w_seg_next;
        end
    end

    assign an_o   = r_an;
    assign seg_o  = r_seg;
    assign busy_o = r_busy;

endmodule
